// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED sequencer:
//   - mode encodings (2-bit): MODE_IDLE, MODE_BLINK, MODE_CHASE, MODE_BOUNCE
//   - entry patterns loaded when a mode is entered
//   - active-low 7-segment digit codes (segment order A..G, MSB = A)
//   - helpers for mode advance, entry pattern and digit lookup
// -----------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam logic [3:0] PAT_IDLE        = 4'b0000;
    localparam logic [3:0] PAT_BLINK_INIT  = 4'b1111;
    localparam logic [3:0] PAT_ONEHOT_INIT = 4'b0001;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;

    // Modes advance in a ring; BOUNCE wraps back to IDLE.
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_IDLE:   n = MODE_BLINK;
            MODE_BLINK:  n = MODE_CHASE;
            MODE_CHASE:  n = MODE_BOUNCE;
            default:     n = MODE_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] entry_pattern(input mode_t m);
        logic [3:0] p;
        case (m)
            MODE_IDLE:   p = PAT_IDLE;
            MODE_BLINK:  p = PAT_BLINK_INIT;
            default:     p = PAT_ONEHOT_INIT;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] seg_digit(input mode_t m);
        logic [6:0] s;
        case (m)
            MODE_IDLE:   s = SEG_0;
            MODE_BLINK:  s = SEG_1;
            MODE_CHASE:  s = SEG_2;
            default:     s = SEG_3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Synchronises a raw asynchronous switch, debounces it and flags presses.
// Parameters:
//   DEBOUNCE_CLKS  clocks the synchronised input must hold a new level (>= 2)
// Ports:
//   i_Clk     in   system clock
//   i_Rst_n   in   asynchronous active-low reset
//   i_Switch  in   raw switch, 1 = pressed, asynchronous to i_Clk
//   o_Level   out  debounced (stable) switch level
//   o_Press   out  one-cycle registered pulse on a stable 0->1 transition
// -----------------------------------------------------------------------------
module switch_debounce #(
    parameter int DEBOUNCE_CLKS = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Press
);

    localparam int CNT_W = (DEBOUNCE_CLKS > 2) ? $clog2(DEBOUNCE_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CLKS - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             press;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            stable  <= 1'b0;
            press   <= 1'b0;
        end else begin
            // Stage boundary: two-flop synchroniser.
            sync_p0 <= i_Switch;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // Any return to the stable level restarts the hold count, so only
            // an uninterrupted mismatch of DEBOUNCE_CLKS clocks is accepted.
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_p1;
                cnt    <= '0;
                press  <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_Level = stable;
    assign o_Press = press;

endmodule

// File: rtl/led_sequence_ctrl.sv
// -----------------------------------------------------------------------------
// led_sequence_ctrl
// Go Board LED sequencer: each debounced press of switch 1 advances the display
// mode (IDLE -> BLINK -> CHASE -> BOUNCE -> IDLE); the LED pattern for the
// active mode steps once per programmable tick.
// Optional feature macro: SEG7_MODE_EN adds a registered 7-segment display of
// the current mode digit (o_Seg, active-low, segments A..G).
// Parameters:
//   CLKS_PER_TICK  clocks per pattern step (>= 2)
//   DEBOUNCE_CLKS  switch debounce hold time in clocks (>= 2)
// Ports:
//   i_Clk       in   system clock
//   i_Rst_n     in   asynchronous active-low reset
//   i_Switch_1  in   raw push switch, 1 = pressed
//   o_Mode      out  current mode (0 IDLE, 1 BLINK, 2 CHASE, 3 BOUNCE)
//   o_LED_1..4  out  pattern bits 0..3
//   o_Seg       out  (SEG7_MODE_EN only) mode digit, active-low A..G
// -----------------------------------------------------------------------------
module led_sequence_ctrl
    import led_seq_pkg::*;
#(
    parameter int CLKS_PER_TICK = 2500000,
    parameter int DEBOUNCE_CLKS = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Switch_1,
    output logic [1:0] o_Mode,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
`ifdef SEG7_MODE_EN
    output logic       o_LED_4,
    output logic [6:0] o_Seg
`else
    output logic       o_LED_4
`endif
);

    localparam int TICK_W = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLKS_PER_TICK - 1);

    logic              press;
    logic              level_unused;   // debounced level is not needed here
    mode_t             mode_q;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [3:0]        pattern;
    logic              dir_up;

    switch_debounce #(
        .DEBOUNCE_CLKS(DEBOUNCE_CLKS)
    ) u_sw1 (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Switch(i_Switch_1),
        .o_Level (level_unused),
        .o_Press (press)
    );

    assign tick = (tick_cnt == TICK_MAX);

    // Stage boundary: mode FSM, tick counter and pattern register.
    // A press takes priority over a coincident tick: the entry pattern loads
    // and the tick counter restarts, so the tick is discarded.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            mode_q   <= MODE_IDLE;
            tick_cnt <= '0;
            pattern  <= PAT_IDLE;
            dir_up   <= 1'b1;
        end else if (press) begin
            mode_q   <= next_mode(mode_q);
            tick_cnt <= '0;
            pattern  <= entry_pattern(next_mode(mode_q));
            dir_up   <= 1'b1;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                case (mode_q)
                    MODE_IDLE:  pattern <= PAT_IDLE;
                    MODE_BLINK: pattern <= ~pattern;
                    MODE_CHASE: pattern <= {pattern[2:0], pattern[3]};
                    default: begin
                        // Direction flips when stepping away from an end,
                        // so each end lit position is shown exactly once.
                        if (dir_up) begin
                            if (pattern[3]) begin
                                pattern <= 4'b0100;
                                dir_up  <= 1'b0;
                            end else begin
                                pattern <= pattern << 1;
                            end
                        end else begin
                            if (pattern[0]) begin
                                pattern <= 4'b0010;
                                dir_up  <= 1'b1;
                            end else begin
                                pattern <= pattern >> 1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign o_Mode  = mode_q;
    assign o_LED_1 = pattern[0];
    assign o_LED_2 = pattern[1];
    assign o_LED_3 = pattern[2];
    assign o_LED_4 = pattern[3];

`ifdef SEG7_MODE_EN
    logic [6:0] seg_q;

    // Stage boundary: digit register, loaded on the same edge as the mode.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            seg_q <= SEG_0;
        end else if (press) begin
            seg_q <= seg_digit(next_mode(mode_q));
        end
    end

    assign o_Seg = seg_q;
`endif

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_sequence_ctrl
// Directed bench for led_sequence_ctrl with CLKS_PER_TICK=4, DEBOUNCE_CLKS=8.
// Works with and without SEG7_MODE_EN defined.
// -----------------------------------------------------------------------------
module tb_led_sequence_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw = 1'b0;
    logic [1:0] mode;
    logic       led1, led2, led3, led4;
    logic [3:0] leds;
    int         passed = 0;
    int         failed = 0;
    int         total  = 0;

`ifdef SEG7_MODE_EN
    logic [6:0] seg;
    logic [6:0] seg_tab [4] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};
`endif

    always #5 clk = ~clk;

    led_sequence_ctrl #(
        .CLKS_PER_TICK(4),
        .DEBOUNCE_CLKS(8)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_Switch_1(sw),
        .o_Mode    (mode),
        .o_LED_1   (led1),
        .o_LED_2   (led2),
        .o_LED_3   (led3),
`ifdef SEG7_MODE_EN
        .o_LED_4   (led4),
        .o_Seg     (seg)
`else
        .o_LED_4   (led4)
`endif
    );

    assign leds = {led4, led3, led2, led1};

    // Advance n active edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int m, input logic [3:0] pat);
        chk({tag, " mode"}, 32'(mode), 32'(m));
        chk({tag, " leds"}, 32'(leds), 32'(pat));
`ifdef SEG7_MODE_EN
        chk({tag, " seg"}, 32'(seg), 32'(seg_tab[m]));
`endif
    endtask

    // Clean press: mode updates 11 edges after the rise, then release and
    // let the release debounce finish (12 edges).
    task automatic press_check(input string tag, input int m, input logic [3:0] pat);
        sw = 1'b1;
        step(11);
        chk_state(tag, m, pat);
        sw = 1'b0;
        step(12);
    endtask

    initial begin
        // 1. Reset held while the switch toggles every clock.
        for (int i = 0; i < 8; i++) begin
            sw = ~sw;
            step(1);
            chk_state("reset_hold", 0, 4'b0000);
        end
        sw = 1'b0;
        rst_n = 1'b1;
        step(3);

        // 2. Short glitch then fast toggling: nothing may change.
        sw = 1'b1;
        step(5);
        sw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            sw = ~sw;
            step(1);
        end
        sw = 1'b0;
        step(12);
        chk_state("glitch", 0, 4'b0000);

        // 3. Clean press held 20 clocks, BLINK timing, then release.
        sw = 1'b1;
        step(10);
        chk_state("press_edge10", 0, 4'b0000);
        step(1);
        chk_state("press_edge11", 1, 4'b1111);
        step(3);
        chk_state("blink_pre_tick", 1, 4'b1111);
        step(1);
        chk_state("blink_tick1", 1, 4'b0000);
        step(4);
        chk_state("blink_tick2", 1, 4'b1111);
        step(1);
        sw = 1'b0;
        step(15);
        chk_state("release_no_change", 1, 4'b1111);

        // 4. Press into CHASE and follow the rotation while held.
        sw = 1'b1;
        step(11);
        chk_state("chase_entry", 2, 4'b0001);
        step(4);
        chk_state("chase_1", 2, 4'b0010);
        step(4);
        chk_state("chase_2", 2, 4'b0100);
        step(4);
        chk_state("chase_3", 2, 4'b1000);
        step(4);
        chk_state("chase_wrap", 2, 4'b0001);
        sw = 1'b0;
        step(12);

        // 5. Press into BOUNCE and follow the sweep while held.
        sw = 1'b1;
        step(11);
        chk_state("bounce_entry", 3, 4'b0001);
        step(4);
        chk_state("bounce_1", 3, 4'b0010);
        step(4);
        chk_state("bounce_2", 3, 4'b0100);
        step(4);
        chk_state("bounce_3", 3, 4'b1000);
        step(4);
        chk_state("bounce_4", 3, 4'b0100);
        step(4);
        chk_state("bounce_5", 3, 4'b0010);
        step(4);
        chk_state("bounce_6", 3, 4'b0001);
        sw = 1'b0;
        // Entry was edge E; now at E+24. Rise after edge E+37 makes the mode
        // change land on edge E+48, which is also a tick edge.
        step(13);
        sw = 1'b1;
        step(10);
        chk_state("bounce_before_wrap", 3, 4'b0010);
        step(1);
        chk_state("press_on_tick_wrap", 0, 4'b0000);
        sw = 1'b0;
        step(12);
        chk_state("idle_after_wrap", 0, 4'b0000);

        // 6. Asynchronous reset mid-CHASE.
        press_check("reblink", 1, 4'b1111);
        sw = 1'b1;
        step(11);
        chk_state("chase_again", 2, 4'b0001);
        step(5);
        chk_state("chase_mid", 2, 4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("async_reset", 0, 4'b0000);
        sw = 1'b0;
        step(2);
        chk_state("reset_held", 0, 4'b0000);
        rst_n = 1'b1;
        step(2);
        press_check("post_reset_press", 1, 4'b1111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global bound so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
